ifetch_seq32: RTL and testbench
===============================

// Module: ifetch_seq32
// PURPOSE
//  Sequential instruction-fetch / PC unit of the MIPS CPU; the upstream end of the execute stage's branch interface.
//  Holds PC, fetches each word from a variable-latency instruction memory via req/ack.
//  Presents Instruction/PC_plus_4 to decode+execute, then consumes Addr_Result, Zero, Read_data_1 and jump flags to select next PC.
//  Replaces the combinational fetch path so the CPU tolerates multi-cycle program memory (UART-loaded RAM).
// PARAMETERS
//  RESET_PC        32'h0000_0000  PC value loaded on reset
//  TIMEOUT_CYCLES  255            max wait for imem_ack (used only with IFETCH_TIMEOUT_EN)
// PORTS
//  clock        in   1   system clock, all state on rising edge
//  reset_n      in   1   synchronous reset, active-low
//  imem_req     out  1   fetch request, held until imem_ack
//  imem_addr    out  32  word address of fetch (= PC), stable while imem_req=1
//  imem_rdata   in   32  instruction word, valid when imem_ack=1
//  imem_ack     in   1   one-cycle fetch completion
//  Instruction  out  32  registered instruction word to decode/execute
//  instr_valid  out  1   Instruction valid; commit when instr_valid & ~stall_in
//  PC           out  32  address of current Instruction
//  PC_plus_4    out  32  PC+4 (combinational from PC register)
//  link_addr    out  32  registered PC+4 of last committed jal
//  Addr_Result  in   32  branch target from execute
//  Zero         in   1   execute equality flag
//  Read_data_1  in   32  rs value, jr target
//  Branch       in   1   beq;  nBranch in 1  bne
//  Jmp          in   1   j;    Jal in 1  jal;  Jr in 1  jr
//  stall_in     in   1   downstream hold; blocks commit
//  fetch_err    out  1   sticky timeout flag (0 when IFETCH_TIMEOUT_EN undefined)
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): PC=RESET_PC, state=IDLE, imem_req=0, instr_valid=0, Instruction=0,
//    link_addr=0, fetch_err=0, timeout counter=0. Reset wins over any same-cycle ack/commit.
//  - FSM: IDLE -> FETCH (unconditional, 1 cycle after reset release).
//    FETCH: imem_req=1, imem_addr=PC; on imem_ack: Instruction<=imem_rdata, instr_valid<=1, -> EXEC.
//    EXEC: instr_valid=1, imem_req=0; if stall_in: hold everything; else commit: PC<=next_pc,
//      instr_valid<=0, -> FETCH. HALT (timeout only): req=0, instr_valid=0 until reset.
//  - Throughput: 2 cycles/instr when ack arrives in first FETCH cycle; +1 per wait cycle, +1 per stall cycle.
//  - next_pc priority: Jr -> {Read_data_1[31:2],2'b00}; else Jmp|Jal -> {PC_plus_4[31:28],Instruction[25:0],2'b00};
//    else (Branch&Zero)|(nBranch&~Zero) -> Addr_Result; else PC_plus_4. Branch and nBranch both 1 -> always taken.
//  - Jal commit: link_addr<=PC_plus_4 same edge as PC update; otherwise link_addr holds.
//  - PC arithmetic mod 2^32: PC=32'hFFFF_FFFC -> PC_plus_4=0, sequential next_pc wraps to 0.
//  - imem_ack outside FETCH ignored (no state change). Jump/branch inputs ignored outside EXEC commit.
//  - Reset mid-FETCH: req drops at that edge; late ack after reset (in IDLE) discarded.
// CONFIGURATION
//  IFETCH_TIMEOUT_EN defined: counter counts FETCH cycles without ack, cleared on entering FETCH;
//    at TIMEOUT_CYCLES waits -> fetch_err<=1 (sticky), state->HALT.
//  Undefined: no counter, FETCH waits indefinitely, fetch_err tied 0, HALT unreachable.
// TESTING
//  1 Reset RESET_PC=0, ack same cycle as req each fetch, no jumps -> imem_addr 0,4,8 on cycles 1,3,5; instr_valid every other cycle.
//  2 PC=0x10, Branch=1, Zero=1, Addr_Result=0x40 at commit -> next imem_addr=0x40; Zero=0 -> 0x14; nBranch=1,Zero=0 -> 0x40.
//  3 PC=0x0040_0008, Instruction=32'h0C00_0100, Jal=1 -> PC=0x0000_0400, link_addr=0x0040_000C; Jr=1, Jmp=1, Read_data_1=0x123 -> PC=0x120.
//  4 stall_in=1 for 3 EXEC cycles -> Instruction, PC, instr_valid held, imem_req=0; commit on first stall_in=0 cycle.
//  5 ack delayed 4 cycles, reset_n=0 in 2nd wait cycle -> req=0 next cycle, PC=RESET_PC; stray ack in IDLE ignored.
//  6 IFETCH_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack -> fetch_err=1 after 8 wait cycles, req=0, HALT until reset.

Source files
------------

// File: rtl/ifetch_seq32.sv
// Sequential MIPS instruction-fetch / PC unit: fetches each word over a req/ack port, then selects the next PC.
// Optional feature macro: IFETCH_TIMEOUT_EN (fetch watchdog driving fetch_err and the HALT state).
module ifetch_seq32 #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] Instruction,
  output logic        instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PC_plus_4,
  output logic [31:0] link_addr,
  input  logic [31:0] Addr_Result,
  input  logic        Zero,
  input  logic [31:0] Read_data_1,
  input  logic        Branch,
  input  logic        nBranch,
  input  logic        Jmp,
  input  logic        Jal,
  input  logic        Jr,
  input  logic        stall_in,
  output logic        fetch_err,
  output logic [1:0]  dbg_state
);

  // Handshakes: imem_req rises with a stable imem_addr and stays high until the
  // one-cycle imem_ack; instr_valid is the downstream "valid" and stall_in its
  // inverted "ready", so an instruction commits only when instr_valid & ~stall_in.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] next_pc;
  logic [31:0] jr_target;
  logic        branch_taken;

  assign PC_plus_4 = PC + 32'd4;
  assign imem_addr = PC;
  assign dbg_state = state;
  assign jr_target = Read_data_1 & 32'hFFFF_FFFC;

  // Branch and nBranch asserted together always take the branch.
  assign branch_taken = (Branch & Zero) | (nBranch & ~Zero);

  always_comb begin
    next_pc = PC_plus_4;
    if (Jr)
      next_pc = jr_target;
    else if (Jmp | Jal)
      next_pc = {PC_plus_4[31:28], Instruction[25:0], 2'b00};
    else if (branch_taken)
      next_pc = Addr_Result;
  end

`ifdef IFETCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
`else
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      PC          <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      Instruction <= 32'd0;
      link_addr   <= 32'd0;
`ifdef IFETCH_TIMEOUT_EN
      fetch_err   <= 1'b0;
      to_cnt      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
`ifdef IFETCH_TIMEOUT_EN
          to_cnt   <= '0;
`endif
        end
        S_FETCH: begin
          if (imem_ack) begin
            Instruction <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= S_EXEC;
          end
`ifdef IFETCH_TIMEOUT_EN
          else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            fetch_err <= 1'b1;
            imem_req  <= 1'b0;
            state     <= S_HALT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        S_EXEC: begin
          if (!stall_in) begin
            PC          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= S_FETCH;
            if (Jal)
              link_addr <= PC_plus_4;
`ifdef IFETCH_TIMEOUT_EN
            to_cnt      <= '0;
`endif
          end
        end
        default: begin
          // HALT: parked until reset.
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_seq32.sv
// Self-checking bench for ifetch_seq32: table of fetch/commit vectors plus hand-written reset and timeout sequences.
// Define IFETCH_TIMEOUT_EN on both design and bench to exercise the fetch watchdog.
module tb_ifetch_seq32;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TO     = 8;

  logic        clock;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] Instruction;
  logic        instr_valid;
  logic [31:0] PC;
  logic [31:0] PC_plus_4;
  logic [31:0] link_addr;
  logic [31:0] Addr_Result;
  logic        Zero;
  logic [31:0] Read_data_1;
  logic        Branch;
  logic        nBranch;
  logic        Jmp;
  logic        Jal;
  logic        Jr;
  logic        stall_in;
  logic        fetch_err;
  logic [1:0]  dbg_state;

  ifetch_seq32 #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .Instruction(Instruction), .instr_valid(instr_valid), .PC(PC), .PC_plus_4(PC_plus_4),
    .link_addr(link_addr), .Addr_Result(Addr_Result), .Zero(Zero), .Read_data_1(Read_data_1),
    .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal), .Jr(Jr),
    .stall_in(stall_in), .fetch_err(fetch_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_link_cur;
  int          prev_req_cyc;
  int          prev_extra;
  bit          have_prev;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] rdata;
    logic [31:0] addr_res;
    logic [31:0] rd1;
    logic        br, nbr, zero, jmp, jal, jr;
    int          dly;
    int          stall;
    logic [31:0] exp_next;
    logic [31:0] exp_link;
  } vec_t;

  vec_t vt[16];

  // flags = {Branch, nBranch, Zero, Jmp, Jal, Jr}
  function automatic vec_t mk(input logic [31:0] rdata, input logic [31:0] addr_res,
                              input logic [31:0] rd1, input logic [5:0] flags,
                              input int dly, input int stall,
                              input logic [31:0] exp_next, input logic [31:0] exp_link);
    vec_t v;
    v.rdata = rdata; v.addr_res = addr_res; v.rd1 = rd1;
    v.br = flags[5]; v.nbr = flags[4]; v.zero = flags[3];
    v.jmp = flags[2]; v.jal = flags[1]; v.jr = flags[0];
    v.dly = dly; v.stall = stall; v.exp_next = exp_next; v.exp_link = exp_link;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_ctrl();
    Branch = 0; nBranch = 0; Zero = 0; Jmp = 0; Jal = 0; Jr = 0;
    Addr_Result = 32'd0; Read_data_1 = 32'd0;
  endtask

  task automatic wait_req(output bit ok);
    int n;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clock);
      n++;
    end
    ok = imem_req;
  endtask

  task automatic pop_addr(input string name);
    if (exp_q.size() == 0) check({name, "_sb_empty"}, 32'd1, 32'd0);
    else check(name, imem_addr, exp_q.pop_front());
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = $urandom;
    stall_in = 1'b0;
    clear_ctrl();
    repeat (3) @(negedge clock);
    imem_ack = 1'b0;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", Instruction, 32'd0);
    check("rst_pc", PC, RST_PC);
    check("rst_link", link_addr, 32'd0);
    check("rst_err", {31'd0, fetch_err}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    reset_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(RST_PC);
    exp_link_cur = 32'd0;
    have_prev = 0;
    @(negedge clock);
  endtask

  task automatic do_instr(input vec_t v, input logic [31:0] pc_exp);
    bit ok;
    wait_req(ok);
    check("req_seen", {31'd0, ok}, 32'd1);
    if (!ok) return;
    pop_addr("imem_addr");
    if (have_prev) check("cycles_per_instr", cyc - prev_req_cyc, 2 + prev_extra);
    prev_req_cyc = cyc;
    prev_extra = v.dly + v.stall;
    have_prev = 1;
    check("pc_plus_4", PC_plus_4, pc_exp + 32'd4);
    // Wait cycles with junk on the jump inputs: FETCH must ignore them.
    for (int i = 0; i < v.dly; i++) begin
      Jr = 1; Jal = 1; Read_data_1 = $urandom; imem_rdata = $urandom;
      @(negedge clock);
      check("req_held", {31'd0, imem_req}, 32'd1);
      check("addr_stable", imem_addr, pc_exp);
    end
    clear_ctrl();
    imem_ack = 1'b1;
    imem_rdata = v.rdata;
    @(negedge clock);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    check("instr", Instruction, v.rdata);
    check("instr_valid", {31'd0, instr_valid}, 32'd1);
    check("req_low_exec", {31'd0, imem_req}, 32'd0);
    check("pc", PC, pc_exp);
    Branch = v.br; nBranch = v.nbr; Zero = v.zero;
    Jmp = v.jmp; Jal = v.jal; Jr = v.jr;
    Addr_Result = v.addr_res; Read_data_1 = v.rd1;
    exp_q.push_back(v.exp_next);
    // Stall cycles also carry a stray ack that EXEC must ignore.
    for (int i = 0; i < v.stall; i++) begin
      stall_in = 1'b1;
      imem_ack = 1'b1;
      imem_rdata = ~v.rdata;
      @(negedge clock);
      check("stall_instr", Instruction, v.rdata);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_req", {31'd0, imem_req}, 32'd0);
      check("stall_pc", PC, pc_exp);
      check("stall_link", link_addr, exp_link_cur);
    end
    stall_in = 1'b0;
    imem_ack = 1'b0;
    @(negedge clock);
    clear_ctrl();
    check("link_addr", link_addr, v.exp_link);
    check("valid_after_commit", {31'd0, instr_valid}, 32'd0);
    exp_link_cur = v.exp_link;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit ok;
    logic [31:0] pc_m;

    vt[0]  = mk(32'h2000_0001, 32'd0,         32'd0,         6'b000000, 0, 0, 32'h0000_0004, 32'h0);
    vt[1]  = mk(32'h2000_0002, 32'd0,         32'd0,         6'b000000, 0, 0, 32'h0000_0008, 32'h0);
    vt[2]  = mk(32'h0800_0004, 32'd0,         32'd0,         6'b000100, 1, 0, 32'h0000_0010, 32'h0);
    vt[3]  = mk(32'h1000_000C, 32'h40,        32'd0,         6'b101000, 0, 3, 32'h0000_0040, 32'h0);
    vt[4]  = mk(32'h1000_000C, 32'h80,        32'd0,         6'b100000, 2, 0, 32'h0000_0044, 32'h0);
    vt[5]  = mk(32'h1400_000C, 32'h100,       32'd0,         6'b010000, 0, 1, 32'h0000_0100, 32'h0);
    vt[6]  = mk(32'h1400_000C, 32'h200,       32'd0,         6'b011000, 0, 0, 32'h0000_0104, 32'h0);
    vt[7]  = mk(32'h1000_000C, 32'h300,       32'd0,         6'b110000, 0, 0, 32'h0000_0300, 32'h0);
    vt[8]  = mk(32'h0C00_0100, 32'd0,         32'd0,         6'b000010, 0, 0, 32'h0000_0400, 32'h304);
    vt[9]  = mk(32'h0000_0008, 32'd0,         32'h123,       6'b000101, 0, 0, 32'h0000_0120, 32'h304);
    vt[10] = mk(32'h0000_0008, 32'h40,        32'h0040_0008, 6'b101001, 0, 0, 32'h0040_0008, 32'h304);
    vt[11] = mk(32'h0C00_0100, 32'd0,         32'd0,         6'b000010, 3, 2, 32'h0000_0400, 32'h0040_000C);
    vt[12] = mk(32'h0000_0008, 32'd0,         32'hFFFF_FFFF, 6'b000001, 0, 0, 32'hFFFF_FFFC, 32'h0040_000C);
    vt[13] = mk(32'h2000_0003, 32'd0,         32'd0,         6'b000000, 0, 0, 32'h0000_0000, 32'h0040_000C);
    vt[14] = mk(32'h0BFF_FFFF, 32'd0,         32'd0,         6'b000100, 0, 0, 32'h0FFF_FFFC, 32'h0040_000C);
    vt[15] = mk(32'h0800_0001, 32'd0,         32'd0,         6'b000100, 1, 1, 32'h1000_0004, 32'h0040_000C);

    reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; stall_in = 1'b0;
    clear_ctrl();
    @(negedge clock);

    do_reset();
    pc_m = RST_PC;
    for (int i = 0; i < 16; i++) begin
      do_instr(vt[i], pc_m);
      pc_m = vt[i].exp_next;
    end

    // Reset during the 2nd wait cycle of a fetch; a stray ack in IDLE is dropped.
    wait_req(ok);
    check("t5_req_seen", {31'd0, ok}, 32'd1);
    pop_addr("t5_addr");
    check("t5_fetch_state", {30'd0, dbg_state}, 32'd1);
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    check("t5_req_drop", {31'd0, imem_req}, 32'd0);
    check("t5_pc", PC, RST_PC);
    check("t5_idle", {30'd0, dbg_state}, 32'd0);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    reset_n = 1'b1;
    @(negedge clock);
    imem_ack = 1'b0;
    check("t5_stray_valid", {31'd0, instr_valid}, 32'd0);
    check("t5_stray_instr", Instruction, 32'd0);
    check("t5_fetch_again", {31'd0, imem_req}, 32'd1);
    check("t5_link_cleared", link_addr, 32'd0);
    exp_q.delete();
    exp_q.push_back(RST_PC);
    exp_link_cur = 32'd0;
    have_prev = 0;
    do_instr(vt[0], RST_PC);
    do_instr(vt[1], vt[0].exp_next);

`ifdef IFETCH_TIMEOUT_EN
    do_reset();
    wait_req(ok);
    check("to_req_seen", {31'd0, ok}, 32'd1);
    pop_addr("to_addr");
    repeat (TO - 1) @(negedge clock);
    check("to_not_yet", {31'd0, fetch_err}, 32'd0);
    check("to_req_still", {31'd0, imem_req}, 32'd1);
    @(negedge clock);
    check("to_err", {31'd0, fetch_err}, 32'd1);
    check("to_req_low", {31'd0, imem_req}, 32'd0);
    check("to_halt", {30'd0, dbg_state}, 32'd3);
    imem_ack = 1'b1;
    imem_rdata = $urandom;
    repeat (3) @(negedge clock);
    imem_ack = 1'b0;
    check("to_halt_hold", {30'd0, dbg_state}, 32'd3);
    check("to_halt_valid", {31'd0, instr_valid}, 32'd0);
    check("to_err_sticky", {31'd0, fetch_err}, 32'd1);
    do_reset();
    check("to_err_cleared", {31'd0, fetch_err}, 32'd0);
`endif

    if (exp_q.size() > 1) check("sb_leftover", exp_q.size(), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
